// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - MEM-to-WB bundle: MEM-stage inputs and WB write-port outputs
interface mem_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              MEM_Valid;
  logic              MEM_Stall;
  logic              MEM_Flush;
  logic              MEM_RF_WrEn;
  logic [REG_AW-1:0] MEM_RdAddr;
  logic [1:0]        MEM_WbSel;
  logic [DATA_W-1:0] ALU_MEM_Addr;
  logic [DATA_W-1:0] MEM_DataOut;
  logic [DATA_W-1:0] MEM_PC4;
  logic [DATA_W-1:0] MEM_Imm;

  logic              WB_Valid;
  logic              WB_RF_WrEn;
  logic [REG_AW-1:0] WB_RdAddr;
  logic [DATA_W-1:0] WB_RF_WrData;

  modport master (
    output MEM_Valid, MEM_Stall, MEM_Flush, MEM_RF_WrEn, MEM_RdAddr, MEM_WbSel,
           ALU_MEM_Addr, MEM_DataOut, MEM_PC4, MEM_Imm,
    input  WB_Valid, WB_RF_WrEn, WB_RdAddr, WB_RF_WrData
  );

  modport slave (
    input  MEM_Valid, MEM_Stall, MEM_Flush, MEM_RF_WrEn, MEM_RdAddr, MEM_WbSel,
           ALU_MEM_Addr, MEM_DataOut, MEM_PC4, MEM_Imm,
    output WB_Valid, WB_RF_WrEn, WB_RdAddr, WB_RF_WrData
  );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register, write-back select and retired counter
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_wb_stage_if.slave    bus,
  input  logic             Cnt_Clr,
  output logic [CNT_W-1:0] Retired_Cnt
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              valid_q, valid_d;
  logic              rf_wren_q, rf_wren_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  retired_cnt_q, retired_cnt_d;
  logic [DATA_W-1:0] sel_data;
  logic              hold;
  logic              retire;

  always_comb begin
    sel_data = bus.ALU_MEM_Addr;
    case (bus.MEM_WbSel)
      2'b00: sel_data = bus.ALU_MEM_Addr;
      2'b01: sel_data = bus.MEM_DataOut;
      2'b10: sel_data = bus.MEM_PC4;
      2'b11: sel_data = bus.MEM_Imm;
    endcase
  end

  // Flush overrides stall, so the slot only truly holds on a stall without flush.
  assign hold   = bus.MEM_Stall & ~bus.MEM_Flush;
  assign retire = valid_q & ~hold;

  always_comb begin
    valid_d       = valid_q;
    rf_wren_d     = rf_wren_q;
    rd_addr_d     = rd_addr_q;
    wr_data_d     = wr_data_q;
    retired_cnt_d = retired_cnt_q;

    if (bus.MEM_Flush) begin
      valid_d   = 1'b0;
      rf_wren_d = 1'b0;
    end else if (!bus.MEM_Stall) begin
      valid_d   = bus.MEM_Valid;
      rf_wren_d = bus.MEM_RF_WrEn & bus.MEM_Valid;
      rd_addr_d = bus.MEM_RdAddr;
      wr_data_d = sel_data;
    end

    if (Cnt_Clr) begin
      retired_cnt_d = '0;
    end else if (retire) begin
      retired_cnt_d = retired_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      rf_wren_q     <= 1'b0;
      rd_addr_q     <= '0;
      wr_data_q     <= '0;
      retired_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      rf_wren_q     <= rf_wren_d;
      rd_addr_q     <= rd_addr_d;
      wr_data_q     <= wr_data_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  // r0 is hard-wired zero, so a write strobe to it is dropped here.
  assign bus.WB_Valid     = valid_q;
  assign bus.WB_RF_WrEn   = valid_q & rf_wren_q & (rd_addr_q != '0);
  assign bus.WB_RdAddr    = rd_addr_q;
  assign bus.WB_RF_WrData = wr_data_q;
  assign Retired_Cnt      = retired_cnt_q;
endmodule
